nfc_feature_capture: RTL

//  Data-in consumer for the Get Features command path. Armed by the command FSM's start pulse, it

---
 rtl/nfc_feature_capture_if.sv | 29 ++
 rtl/nfc_feature_capture.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/nfc_feature_capture_if.sv
// Get Features data-in and result bundle between the command path, the atom generator
// read channel and downstream status logic.
interface nfc_feature_capture_if #(
    parameter int NumberOfWays = 4,
    parameter int FeatureBytes = 4
);
    logic                      iStart;
    logic [NumberOfWays-1:0]   iWaySelect;
    logic [15:0]               iACG_ReadData;
    logic                      iACG_ReadLast;
    logic                      iACG_ReadValid;
    logic                      oACG_ReadReady;
    logic [8*FeatureBytes-1:0] oFeatureData;
    logic [NumberOfWays-1:0]   oFeatureWay;
    logic [2:0]                oFeatureError;
    logic                      oFeatureValid;
    logic                      iFeatureReady;
    logic                      oBusy;

    modport master (
        output iStart, iWaySelect, iACG_ReadData, iACG_ReadLast, iACG_ReadValid, iFeatureReady,
        input  oACG_ReadReady, oFeatureData, oFeatureWay, oFeatureError, oFeatureValid, oBusy
    );

    modport slave (
        input  iStart, iWaySelect, iACG_ReadData, iACG_ReadLast, iACG_ReadValid, iFeatureReady,
        output oACG_ReadReady, oFeatureData, oFeatureWay, oFeatureError, oFeatureValid, oBusy
    );
endinterface

// File: rtl/nfc_feature_capture.sv
// Get Features data-in consumer: packs feature bytes P1..Pn, flags lane/short/timeout errors.
// Optional idle-beat timeout is built only when NFC_FEATURE_TIMEOUT_EN is defined.
module nfc_feature_capture #(
    parameter int NumberOfWays  = 4,
    parameter int FeatureBytes  = 4,
    parameter int TimeoutCycles = 1024
) (
    input  logic                 iSystemClock,
    input  logic                 iReset,
    nfc_feature_capture_if.slave bus
);
    localparam int CW = $clog2(FeatureBytes) + 1;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] CAPTURE = 2'd1;
    localparam logic [1:0] DRAIN   = 2'd2;
    localparam logic [1:0] HOLD    = 2'd3;

    localparam logic [CW-1:0] LAST_SLOT = CW'(FeatureBytes - 1);

    if (FeatureBytes < 2 || TimeoutCycles < 1) begin : g_param_check
        $error("nfc_feature_capture: FeatureBytes must be >= 2 and TimeoutCycles >= 1");
    end

    logic [1:0]                r_state;
    logic [1:0]                w_next;
    logic [CW-1:0]             r_count;
    logic [8*FeatureBytes-1:0] r_data;
    logic [NumberOfWays-1:0]   r_way;
    logic [2:0]                r_err;
    logic                      r_ready;
    logic                      r_valid;
    logic                      w_beat;
    logic                      w_lane_err;
    logic                      w_timeout;

    assign w_beat     = bus.iACG_ReadValid & r_ready;
    assign w_lane_err = bus.iACG_ReadData[15:8] != bus.iACG_ReadData[7:0];

`ifdef NFC_FEATURE_TIMEOUT_EN
    localparam int IW = $clog2(TimeoutCycles + 1);

    logic [IW-1:0] r_idle;
    logic          w_waiting;

    assign w_waiting = (r_state == CAPTURE) || (r_state == DRAIN);

    // Outside CAPTURE/DRAIN the counter sits at zero, so state entry always starts a fresh count.
    always_ff @(posedge iSystemClock or negedge iReset) begin
        if (!iReset) begin
            r_idle <= '0;
        end else if (w_waiting && !w_beat) begin
            r_idle <= r_idle + 1'b1;
        end else begin
            r_idle <= '0;
        end
    end

    assign w_timeout = w_waiting && !w_beat && (r_idle == IW'(TimeoutCycles - 1));
`else
    assign w_timeout = 1'b0;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (bus.iStart) w_next = CAPTURE;
            end
            CAPTURE: begin
                if (w_beat) begin
                    if (r_count == LAST_SLOT) begin
                        w_next = bus.iACG_ReadLast ? HOLD : DRAIN;
                    end else if (bus.iACG_ReadLast) begin
                        w_next = HOLD;
                    end
                end else if (w_timeout) begin
                    w_next = HOLD;
                end
            end
            DRAIN: begin
                if ((w_beat && bus.iACG_ReadLast) || w_timeout) w_next = HOLD;
            end
            HOLD: begin
                if (bus.iFeatureReady) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Ready/valid are registered copies of the next state so they line up with the state itself.
    always_ff @(posedge iSystemClock or negedge iReset) begin
        if (!iReset) begin
            r_state <= IDLE;
            r_count <= '0;
            r_data  <= '0;
            r_way   <= '0;
            r_err   <= '0;
            r_ready <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_next;
            r_ready <= (w_next == CAPTURE) || (w_next == DRAIN);
            r_valid <= (w_next == HOLD);
            case (r_state)
                IDLE: begin
                    if (bus.iStart) begin
                        r_way   <= bus.iWaySelect;
                        r_data  <= '0;
                        r_err   <= '0;
                        r_count <= '0;
                    end
                end
                CAPTURE: begin
                    if (w_beat) begin
                        for (int unsigned k = 0; k < FeatureBytes; k++) begin
                            if (r_count == CW'(k)) r_data[8*k +: 8] <= bus.iACG_ReadData[7:0];
                        end
                        if (w_lane_err) r_err[0] <= 1'b1;
                        if (bus.iACG_ReadLast && (r_count != LAST_SLOT)) r_err[1] <= 1'b1;
                        r_count <= r_count + 1'b1;
                    end else if (w_timeout) begin
                        r_err[2] <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (w_timeout) r_err[2] <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.oACG_ReadReady = r_ready;
    assign bus.oFeatureData   = r_data;
    assign bus.oFeatureWay    = r_way;
    assign bus.oFeatureError  = r_err;
    assign bus.oFeatureValid  = r_valid;
    assign bus.oBusy          = (r_state != IDLE);
endmodule
